// File: rtl/alu_taylor_pkg.sv
// rtl/alu_taylor_pkg.sv - shared Q1.16 types, selects, last indices, states and arithmetic helpers
package alu_taylor_pkg;

    localparam int Q_W    = 18;
    localparam int Q_FRAC = 16;

    typedef logic signed [Q_W-1:0] q_t;

    localparam q_t Q_ONE = 18'sh10000;

    localparam logic [2:0] ALU_TAYLOR_SIN          = 3'd0;
    localparam logic [2:0] ALU_TAYLOR_COS          = 3'd1;
    localparam logic [2:0] ALU_TAYLOR_INV_1_PLUS_X = 3'd2;

    localparam logic [3:0] TAYLOR_LAST_IDX_SIN          = 4'd10;
    localparam logic [3:0] TAYLOR_LAST_IDX_COS          = 4'd9;
    localparam logic [3:0] TAYLOR_LAST_IDX_INV_1_PLUS_X = 4'd9;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACC   = 3'd1;
    localparam logic [2:0] ST_POW   = 3'd2;
    localparam logic [2:0] ST_SCALE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic q_t sat_q(input logic signed [35:0] v);
        if (v > 36'sd131071)
            return 18'sh1FFFF;
        else if (v < -36'sd131072)
            return 18'sh20000;
        else
            return v[17:0];
    endfunction

    // Round-to-nearest by adding half an LSB before dropping the fractional bits.
    function automatic q_t mul_rnd(input logic signed [35:0] prod);
        logic signed [35:0] r;
        r = (prod + 36'sd32768) >>> Q_FRAC;
        return sat_q(r);
    endfunction

    function automatic q_t add_sat(input q_t a, input q_t b);
        logic signed [35:0] s;
        s = {{18{a[17]}}, a} + {{18{b[17]}}, b};
        return sat_q(s);
    endfunction

    function automatic logic [3:0] last_idx(input logic [2:0] sel);
        case (sel)
            ALU_TAYLOR_SIN:          return TAYLOR_LAST_IDX_SIN;
            ALU_TAYLOR_COS:          return TAYLOR_LAST_IDX_COS;
            ALU_TAYLOR_INV_1_PLUS_X: return TAYLOR_LAST_IDX_INV_1_PLUS_X;
            default:                 return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu_taylor_inv_n.sv
// rtl/alu_taylor_inv_n.sv - combinational 1/n reciprocal ROM in Q1.16
module alu_taylor_inv_n
    import alu_taylor_pkg::*;
(
    input  logic [3:0] idx,
    output q_t         inv
);

    always_comb begin
        inv = '0;
        case (idx)
            4'd1:    inv = 18'sh10000;
            4'd2:    inv = 18'sh08000;
            4'd3:    inv = 18'sh05555;
            4'd4:    inv = 18'sh04000;
            4'd5:    inv = 18'sh03333;
            4'd6:    inv = 18'sh02AAB;
            4'd7:    inv = 18'sh02492;
            4'd8:    inv = 18'sh02000;
            4'd9:    inv = 18'sh01C72;
            4'd10:   inv = 18'sh0199A;
            default: inv = '0;
        endcase
    end

endmodule

// File: rtl/alu_taylor_calc.sv
// rtl/alu_taylor_calc.sv - sequential Taylor-series evaluator sharing one 18x18 multiplier
module alu_taylor_calc
    import alu_taylor_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  function_sel,
    input  logic [17:0] x_in,
    output logic [2:0]  tbl_function_sel,
    output logic [3:0]  tbl_idx,
    input  logic [17:0] tbl_deriv_coef,
    output logic        busy,
    output logic        done,
    output logic [17:0] result
);

    logic [2:0]         state;
    logic [2:0]         func;
    logic [3:0]         n;
    logic [3:0]         last;
    logic [3:0]         inv_idx;
    q_t                 x;
    q_t                 p;
    q_t                 t;
    q_t                 acc;
    q_t                 inv_val;
    q_t                 mul_a;
    q_t                 mul_b;
    logic signed [35:0] prod;
    q_t                 prod_q;
    q_t                 acc_sum;

    assign inv_idx = n + 4'd1;

    alu_taylor_inv_n u_inv_n (
        .idx (inv_idx),
        .inv (inv_val)
    );

    // Operand mux in front of the single multiplier, steered by the phase of the term loop.
    always_comb begin
        mul_a = p;
        mul_b = x;
        case (state)
            ST_ACC: begin
                mul_a = tbl_deriv_coef;
                mul_b = p;
            end
            ST_SCALE: begin
                mul_a = t;
                mul_b = inv_val;
            end
            default: begin
                mul_a = p;
                mul_b = x;
            end
        endcase
    end

    assign prod    = mul_a * mul_b;
    assign prod_q  = mul_rnd(prod);
    assign acc_sum = add_sat(acc, prod_q);

    assign tbl_idx          = n;
    assign tbl_function_sel = func;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            func   <= '0;
            n      <= '0;
            last   <= '0;
            x      <= '0;
            p      <= '0;
            t      <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        func  <= function_sel;
                        x     <= x_in;
                        n     <= '0;
                        p     <= Q_ONE;
                        acc   <= '0;
                        last  <= last_idx(function_sel);
                        busy  <= 1'b1;
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc <= acc_sum;
                    if (n == last) begin
                        result <= acc_sum;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        state <= ST_POW;
                    end
                end
                ST_POW: begin
                    t     <= prod_q;
                    state <= ST_SCALE;
                end
                ST_SCALE: begin
                    p     <= prod_q;
                    n     <= n + 4'd1;
                    state <= ST_ACC;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_taylor_calc.sv
// tb/tb_alu_taylor_calc.sv - randomized self-checking bench with a coefficient table and reference model
module tb_alu_taylor_calc;
    import alu_taylor_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  function_sel;
    logic [17:0] x_in;
    logic [2:0]  tbl_function_sel;
    logic [3:0]  tbl_idx;
    logic [17:0] tbl_deriv_coef;
    logic        busy;
    logic        done;
    logic [17:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] inv_coef [16];
    longint      inv_ref  [11];

    always #5 clk = ~clk;

    alu_taylor_calc dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .function_sel     (function_sel),
        .x_in             (x_in),
        .tbl_function_sel (tbl_function_sel),
        .tbl_idx          (tbl_idx),
        .tbl_deriv_coef   (tbl_deriv_coef),
        .busy             (busy),
        .done             (done),
        .result           (result)
    );

    function automatic logic [17:0] coef_of(input logic [2:0] sel, input logic [3:0] idx);
        case (sel)
            ALU_TAYLOR_SIN: begin
                case (idx[1:0])
                    2'd1:    return 18'h10000;
                    2'd3:    return 18'h30000;
                    default: return 18'h00000;
                endcase
            end
            ALU_TAYLOR_COS: begin
                case (idx[1:0])
                    2'd0:    return 18'h10000;
                    2'd2:    return 18'h30000;
                    default: return 18'h00000;
                endcase
            end
            ALU_TAYLOR_INV_1_PLUS_X: return inv_coef[idx];
            default:                 return 18'h00000;
        endcase
    endfunction

    always_comb tbl_deriv_coef = coef_of(tbl_function_sel, tbl_idx);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [17:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic longint rmul(input longint a, input longint b);
        return clamp((a * b + 32768) >>> 16);
    endfunction

    function automatic int model_last(input logic [2:0] sel);
        case (sel)
            ALU_TAYLOR_SIN:          return 10;
            ALU_TAYLOR_COS:          return 9;
            ALU_TAYLOR_INV_1_PLUS_X: return 9;
            default:                 return 0;
        endcase
    endfunction

    // Sum of coef[n] * x^n/n!, with every step rounded and clamped to Q1.16.
    function automatic logic [17:0] model_eval(input logic [2:0] sel, input logic [17:0] xv);
        longint acc, p, xs, tt;
        logic [17:0] r;
        int L;
        L   = model_last(sel);
        acc = 0;
        p   = 65536;
        xs  = sx(xv);
        for (int k = 0; k <= L; k++) begin
            acc = clamp(acc + rmul(sx(coef_of(sel, 4'(k))), p));
            if (k < L) begin
                tt = rmul(p, xs);
                p  = rmul(tt, inv_ref[k+1]);
            end
        end
        r = acc[17:0];
        return r;
    endfunction

    task automatic run_eval(input string tag, input logic [2:0] sel, input logic [17:0] xv,
                            input bit poke, output logic [17:0] got);
        int L;
        int dc;
        logic [17:0] exp;
        L   = model_last(sel);
        exp = model_eval(sel, xv);
        dc  = 0;
        @(negedge clk);
        function_sel = sel;
        x_in         = xv;
        start        = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            @(negedge clk);
            start = (poke && c == 5);
            check_eq({tag, "_busy"}, busy, 1);
            if (c == 1)
                check_eq({tag, "_tbl_sel"}, tbl_function_sel, sel);
            if (c <= 3*L+1 && (c-1) % 3 == 0)
                check_eq({tag, "_tbl_idx"}, tbl_idx, (c-1)/3);
            if (done) dc = c;
        end
        start = 1'b0;
        check_eq({tag, "_done_cycle"}, dc, 3*L+2);
        check_eq({tag, "_result"}, result, exp);
        got = result;
        @(negedge clk);
        check_eq({tag, "_done_low"}, done, 0);
        check_eq({tag, "_busy_low"}, busy, 0);
        @(negedge clk);
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_done"}, done, 0);
    endtask

    logic [17:0] got;
    logic [2:0]  sel_pool [4];
    longint      diff;

    initial begin
        inv_ref = '{0, 'h10000, 'h08000, 'h05555, 'h04000, 'h03333,
                    'h02AAB, 'h02492, 'h02000, 'h01C72, 'h0199A};
        for (int i = 0; i < 16; i++) inv_coef[i] = 18'($urandom_range(0, 262143));
        sel_pool = '{ALU_TAYLOR_SIN, ALU_TAYLOR_COS, ALU_TAYLOR_INV_1_PLUS_X, 3'b111};

        reset_n = 1'b0;
        start = 1'b0;
        function_sel = '0;
        x_in = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_tbl_idx", tbl_idx, 0);
        check_eq("rst_tbl_sel", tbl_function_sel, 0);
        reset_n = 1'b1;

        run_eval("cos0", ALU_TAYLOR_COS, 18'h00000, 1'b0, got);
        check_eq("cos0_one", got, 18'h10000);

        // Asynchronous reset in the middle of a SIN run.
        @(negedge clk);
        function_sel = ALU_TAYLOR_SIN;
        x_in = 18'h10000;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_result", result, 0);
        check_eq("midrst_tbl_idx", tbl_idx, 0);
        check_eq("midrst_tbl_sel", tbl_function_sel, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_eval("sin_p1", ALU_TAYLOR_SIN, 18'h10000, 1'b0, got);
        diff = sx(got) - sx(18'h0D76B);
        check_eq("sin_p1_tol", (diff >= -4 && diff <= 4), 1);
        run_eval("sin_m1", ALU_TAYLOR_SIN, 18'h30000, 1'b0, got);
        diff = sx(got) - sx(18'h32895);
        check_eq("sin_m1_tol", (diff >= -4 && diff <= 4), 1);
        run_eval("unsup", 3'b111, 18'h0ABCD, 1'b0, got);
        check_eq("unsup_zero", got, 0);
        run_eval("cos_poke", ALU_TAYLOR_COS, 18'h08000, 1'b1, got);
        run_eval("inv", ALU_TAYLOR_INV_1_PLUS_X, 18'h04000, 1'b0, got);

        for (int i = 0; i < 8; i++)
            run_eval("rnd", sel_pool[$urandom_range(0, 3)], 18'($urandom_range(0, 262143)), 1'b0, got);

        // start held high: COS runs back-to-back every 30 cycles with result held.
        begin
            int pulses;
            int last_done;
            logic [17:0] held;
            logic [17:0] exp;
            logic [17:0] xv;
            xv = 18'($urandom_range(0, 262143));
            exp = model_eval(ALU_TAYLOR_COS, xv);
            pulses = 0;
            last_done = 0;
            held = '0;
            @(negedge clk);
            function_sel = ALU_TAYLOR_COS;
            x_in = xv;
            start = 1'b1;
            for (int c = 0; c < 130 && pulses < 3; c++) begin
                @(negedge clk);
                if (done) begin
                    if (pulses > 0) check_eq("b2b_period", c - last_done, 30);
                    check_eq("b2b_result", result, exp);
                    held = result;
                    last_done = c;
                    pulses++;
                end else if (pulses > 0) begin
                    check_eq("b2b_hold", result, held);
                end
            end
            start = 1'b0;
            check_eq("b2b_pulses", pulses, 3);
            repeat (2) @(negedge clk);
            check_eq("b2b_idle", busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
